// File: rtl/id_operand_pipe_if.sv
// ID/EX boundary bundle: registered decode results handed to EX.
// master drives (id_operand_pipe), slave consumes (EX).
interface id_operand_pipe_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int SELW = 3
);
  logic [OPW-1:0]  aluop;
  logic [SELW-1:0] alusel;
  logic [DW-1:0]   reg1;
  logic [DW-1:0]   reg2;
  logic [AW-1:0]   wd;
  logic            wreg;
  logic [DW-1:0]   link_addr;
  logic [31:0]     inst;
  logic            in_dslot;

  modport master (
    output aluop, alusel, reg1, reg2, wd,
    output wreg, link_addr, inst, in_dslot
  );

  modport slave (
    input aluop, alusel, reg1, reg2, wd,
    input wreg, link_addr, inst, in_dslot
  );
endinterface

// File: rtl/id_operand_pipe.sv
// Decode-stage operand fetch, forwarding, load-use interlock, branch resolve.
// Define ID_PERF_CNT_EN for branch-taken / load-use stall counters.
module id_operand_pipe #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int OPW  = 8,
  parameter int SELW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DW-1:0]     pc_i,
  input  logic [31:0]       inst_i,
  input  logic [OPW-1:0]    aluop_i,
  input  logic [SELW-1:0]   alusel_i,
  input  logic [AW-1:0]     wd_i,
  input  logic              wreg_i,
  input  logic [DW-1:0]     imm_i,
  input  logic              rd1_en_i,
  input  logic [AW-1:0]     rd1_addr_i,
  input  logic              rd2_en_i,
  input  logic [AW-1:0]     rd2_addr_i,
  input  logic [3:0]        br_type_i,
  input  logic              link_i,
  input  logic [DW-1:0]     rf_rdata1_i,
  input  logic [DW-1:0]     rf_rdata2_i,
  input  logic [NFWD-1:0]   fwd_wreg_i,
  input  logic [NFWD*AW-1:0] fwd_wd_i,
  input  logic [NFWD*DW-1:0] fwd_wdata_i,
  input  logic [NFWD-1:0]   fwd_rdy_i,
  output logic [AW-1:0]     rf_raddr1_o,
  output logic [AW-1:0]     rf_raddr2_o,
  output logic              stallreq_o,
  output logic              branch_flag_o,
  output logic [DW-1:0]     branch_target_o,
  id_operand_pipe_if.master ex
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]       perf_br_taken_o,
  output logic [31:0]       perf_lu_stall_o
`endif
);

  localparam logic [DW-1:0] FOUR  = DW'(4);
  localparam logic [DW-1:0] EIGHT = DW'(8);

  // Returns {hazard, data}; scanning old->young lets the youngest match win.
  function automatic logic [DW:0] sel_op(
    input logic          en,
    input logic [AW-1:0] a,
    input logic [DW-1:0] rf
  );
    logic [DW-1:0] d;
    logic          h;
    d = rf;
    h = 1'b0;
    for (int k = NFWD-1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && fwd_wd_i[k*AW +: AW] == a) begin
        d = fwd_wdata_i[k*DW +: DW];
        h = ~fwd_rdy_i[k];
      end
    end
    if (!en) begin
      d = imm_i;
      h = 1'b0;
    end else if (a == '0) begin
      d = '0;
      h = 1'b0;
    end
    return {h, d};
  endfunction

  logic [DW:0]   s1, s2;
  logic [DW-1:0] op1, op2;
  logic          hz, cap, bub;
  logic [DW-1:0] pc4, jtgt, ctgt, tgt;
  logic          take;
  logic          dslot_q;

  assign s1  = sel_op(rd1_en_i, rd1_addr_i, rf_rdata1_i);
  assign s2  = sel_op(rd2_en_i, rd2_addr_i, rf_rdata2_i);
  assign op1 = s1[DW-1:0];
  assign op2 = s2[DW-1:0];
  assign hz  = s1[DW] | s2[DW];

  assign rf_raddr1_o = rd1_addr_i;
  assign rf_raddr2_o = rd2_addr_i;
  assign stallreq_o  = hz & ~rst;

  assign pc4  = pc_i + FOUR;
  assign jtgt = {pc4[DW-1:28], inst_i[25:0], 2'b00};
  assign ctgt = pc4 + {{(DW-18){inst_i[15]}}, inst_i[15:0], 2'b00};

  always_comb begin
    take = 1'b0;
    tgt  = ctgt;
    case (br_type_i)
      4'd1: begin take = 1'b1; tgt = jtgt; end
      4'd2: begin take = 1'b1; tgt = op1;  end
      4'd3: take = (op1 == op2);
      4'd4: take = (op1 != op2);
      4'd5: take = ~op1[DW-1];
      4'd6: take = ~op1[DW-1] & (op1 != '0);
      4'd7: take = op1[DW-1] | (op1 == '0);
      4'd8: take = op1[DW-1];
      default: take = 1'b0;
    endcase
  end

  assign branch_flag_o   = take & ~hz;
  assign branch_target_o = branch_flag_o ? tgt : '0;

  // Interlock bubbles EX even under stall_i; ctrl holds ID via stallreq_o.
  assign bub = rst | flush_i | hz;
  assign cap = ~bub & ~stall_i;

  always_ff @(posedge clk) begin
    if (bub) begin
      ex.aluop     <= '0;
      ex.alusel    <= '0;
      ex.reg1      <= '0;
      ex.reg2      <= '0;
      ex.wd        <= '0;
      ex.wreg      <= 1'b0;
      ex.link_addr <= '0;
      ex.inst      <= '0;
      ex.in_dslot  <= 1'b0;
    end else if (cap) begin
      ex.aluop     <= aluop_i;
      ex.alusel    <= alusel_i;
      ex.reg1      <= op1;
      ex.reg2      <= op2;
      ex.wd        <= wd_i;
      ex.wreg      <= wreg_i;
      ex.link_addr <= link_i ? pc_i + EIGHT : '0;
      ex.inst      <= inst_i;
      ex.in_dslot  <= dslot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i)
      dslot_q <= 1'b0;
    else if (cap)
      dslot_q <= (br_type_i != 4'd0);
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_taken_o <= '0;
      perf_lu_stall_o <= '0;
    end else begin
      if (branch_flag_o && cap)
        perf_br_taken_o <= perf_br_taken_o + 32'd1;
      if (hz)
        perf_lu_stall_o <= perf_lu_stall_o + 32'd1;
    end
  end
`endif

endmodule
